// File: rtl/instruction_fetch_sequencer_if.sv
// Fetch sequencer bus: run/ack/flush control in,
// datapath and memory strobes plus status out.
interface instruction_fetch_sequencer_if;
  logic       Run;
  logic       Ack;
  logic       Flush;
  logic [1:0] ARF_OutDSel;
  logic [1:0] ARF_FunSel;
  logic [2:0] ARF_RegSel;
  logic       Mem_CS;
  logic       Mem_WR;
  logic       IR_Write;
  logic       IR_LH;
  logic       InstrValid;
  logic [1:0] State;
  logic [7:0] FetchCount;

  modport master (
    input  Run, Ack, Flush,
    output ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    output Mem_CS, Mem_WR, IR_Write, IR_LH,
    output InstrValid, State, FetchCount
  );

  modport slave (
    output Run, Ack, Flush,
    input  ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    input  Mem_CS, Mem_WR, IR_Write, IR_LH,
    input  InstrValid, State, FetchCount
  );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte instruction fetch: loads IR low then high
// from memory at PC, then holds until acknowledged.
module instruction_fetch_sequencer #(
  parameter logic [1:0] PC_OUTDSEL = 2'b00,
  parameter logic [2:0] PC_REGSEL  = 3'b100,
  parameter logic [1:0] ARF_INC    = 2'b01
) (
  input logic Clock,
  input logic Reset,
  instruction_fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FETCH_L = 2'b01,
    FETCH_H = 2'b10,
    HOLD    = 2'b11
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [7:0] fetchCount;
  logic       ackTake;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      fetchCount <= '0;
    end else begin
      state <= nextState;
      if (ackTake) fetchCount <= fetchCount + 8'd1;
    end
  end

  // Flush wins over Ack; Ack only counts out of HOLD
  always_comb begin
    nextState = state;
    ackTake   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Run) nextState = FETCH_L;
      end
      FETCH_L: begin
        nextState = bus.Flush ? IDLE : FETCH_H;
      end
      FETCH_H: begin
        nextState = bus.Flush ? IDLE : HOLD;
      end
      HOLD: begin
        if (bus.Flush) begin
          nextState = IDLE;
        end else if (bus.Ack) begin
          ackTake   = 1'b1;
          nextState = bus.Run ? FETCH_L : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.ARF_OutDSel = PC_OUTDSEL;
    bus.ARF_FunSel  = ARF_INC;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.IR_Write    = 1'b0;
    bus.IR_LH       = 1'b0;
    bus.ARF_RegSel  = 3'b000;
    bus.InstrValid  = 1'b0;
    unique case (1'b1)
      state == FETCH_L: begin
        bus.Mem_CS     = 1'b0;
        bus.IR_Write   = 1'b1;
        bus.ARF_RegSel = PC_REGSEL;
      end
      state == FETCH_H: begin
        bus.Mem_CS     = 1'b0;
        bus.IR_Write   = 1'b1;
        bus.IR_LH      = 1'b1;
        bus.ARF_RegSel = PC_REGSEL;
      end
      state == HOLD: begin
        bus.InstrValid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.State      = state;
  assign bus.FetchCount = fetchCount;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: vector table,
// directed corner sequences and random run against a model.
module tb_instruction_fetch_sequencer;

  localparam logic [1:0] PC_OUTDSEL = 2'b00;
  localparam logic [2:0] PC_REGSEL  = 3'b100;
  localparam logic [1:0] ARF_INC    = 2'b01;

  logic Clock;
  logic Reset;

  instruction_fetch_sequencer_if bus();

  instruction_fetch_sequencer #(
    .PC_OUTDSEL(PC_OUTDSEL),
    .PC_REGSEL (PC_REGSEL),
    .ARF_INC   (ARF_INC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int compared = 0;
  int mismatched = 0;

  // small datapath stand-in: PC register, memory image, IR
  logic [15:0] pc = 16'h0;
  logic [15:0] ir = 16'h0;

  function automatic logic [7:0] memByte(input logic [15:0] a);
    return (a[7:0] * 8'd7 + 8'd3) ^ a[15:8];
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      if (bus.IR_Write && !bus.Mem_CS) begin
        if (bus.IR_LH) ir[15:8] <= memByte(pc);
        else           ir[7:0]  <= memByte(pc);
      end
      if (bus.ARF_RegSel == PC_REGSEL && bus.ARF_FunSel == ARF_INC)
        pc <= pc + 16'd1;
    end
  end

  // reference: an instruction in progress with a count of bytes loaded
  bit          busy = 0;
  int          bytes = 0;
  logic [15:0] pcM = 16'h0;
  logic [15:0] start = 16'h0;
  int          countM = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge(input logic r, input logic a, input logic f);
    if (!busy) begin
      if (r) begin
        busy = 1; bytes = 0; start = pcM;
      end
    end else if (bytes < 2) begin
      pcM = pcM + 16'd1;
      bytes++;
      if (f) busy = 0;
    end else if (f) begin
      busy = 0;
    end else if (a) begin
      countM = (countM + 1) % 256;
      if (r) begin
        bytes = 0; start = pcM;
      end else begin
        busy = 0;
      end
    end
  endtask

  task automatic checkAll();
    bit fetching;
    int expSt;
    fetching = busy && bytes < 2;
    expSt = !busy ? 0 : (fetching ? bytes + 1 : 3);
    chk("State", bus.State, expSt);
    chk("InstrValid", bus.InstrValid, int'(busy && bytes == 2));
    chk("Mem_CS", bus.Mem_CS, int'(!fetching));
    chk("Mem_WR", bus.Mem_WR, 0);
    chk("IR_Write", bus.IR_Write, int'(fetching));
    chk("ARF_RegSel", bus.ARF_RegSel, fetching ? int'(PC_REGSEL) : 0);
    chk("ARF_OutDSel", bus.ARF_OutDSel, int'(PC_OUTDSEL));
    chk("ARF_FunSel", bus.ARF_FunSel, int'(ARF_INC));
    chk("FetchCount", bus.FetchCount, countM);
    chk("PC", pc, pcM);
    if (fetching) chk("IR_LH", bus.IR_LH, bytes);
    if (busy && bytes == 2)
      chk("IR", ir, {memByte(start + 16'd1), memByte(start)});
  endtask

  task automatic step(input logic r, input logic a, input logic f);
    bus.Run = r; bus.Ack = a; bus.Flush = f;
    @(posedge Clock);
    modelEdge(r, a, f);
    @(negedge Clock);
    checkAll();
  endtask

  typedef struct {
    logic       run;
    logic       ack;
    logic       flush;
    logic [1:0] st;
    int         cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [15:0] pc0;
    int          c0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b01, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'b10, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'b11, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'b11, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b10, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b11, 1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 2'b00, 1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 2'b01, 1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 2'b10, 1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 2'b11, 1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 2'b00, 2};

    Reset = 1'b0;
    bus.Run = 1'b0; bus.Ack = 1'b0; bus.Flush = 1'b0;
    #1;
    checkAll();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    // idle with Run low must not start a fetch
    step(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].run, tbl[i].ack, tbl[i].flush);
      chk($sformatf("tblState%0d", i), bus.State, tbl[i].st);
      chk($sformatf("tblCount%0d", i), bus.FetchCount, tbl[i].cnt);
    end

    // back-to-back instructions, Ack in every HOLD
    step(1'b0, 1'b0, 1'b1);
    pc0 = pc;
    c0 = int'(bus.FetchCount);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i % 3 == 2) chk("b2bHold", bus.State, 3);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("b2bCount", bus.FetchCount, (c0 + 4) % 256);
    chk("b2bPc", pc, int'(pc0 + 16'd8));

    // reset asserted between edges while in FETCH_H
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2 Reset = 1'b0;
    #1;
    busy = 0; countM = 0;
    chk("rstState", bus.State, 0);
    chk("rstMemCS", bus.Mem_CS, 1);
    chk("rstIRWrite", bus.IR_Write, 0);
    chk("rstValid", bus.InstrValid, 0);
    chk("rstCount", bus.FetchCount, 0);
    pc0 = pc;
    @(posedge Clock);
    @(negedge Clock);
    chk("rstPcHeld", pc, int'(pc0));
    bus.Run = 1'b0;
    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("rstStayIdle", bus.State, 0);

    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0);

    // drive FetchCount to 255, then one more acknowledge
    for (int i = 0; i < 1200 && countM != 255; i++)
      step(1'b1, 1'b1, 1'b0);
    chk("reach255", countM, 255);
    for (int i = 0; i < 6 && countM == 255; i++)
      step(1'b1, 1'b1, 1'b0);
    chk("wrapZero", bus.FetchCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_sequencer.md
INSTRUCTION_FETCH_SEQUENCER -- requirements
Module: instruction_fetch_sequencer

Interface
REQ-001 Parameter PC_OUTDSEL, default 2'b00: ARF_OutDSel code that routes PC to the memory address.
REQ-002 Parameter PC_REGSEL, default 3'b100: ARF_RegSel code that enables PC only.
REQ-003 Parameter ARF_INC, default 2'b01: ARF_FunSel code for increment.
REQ-004 Clock, input, 1: single clock; all state updates on the rising edge.
REQ-005 Reset, input, 1: asynchronous, active-low reset.
REQ-006 Run, input, 1: 1 = keep fetching instructions.
REQ-007 Ack, input, 1: the execute stage has consumed the held instruction.
REQ-008 Flush, input, 1: abandon the current fetch or held instruction.
REQ-009 ARF_OutDSel, output, 2: address-source select to the datapath.
REQ-010 ARF_FunSel, output, 2: ARF function select.
REQ-011 ARF_RegSel, output, 3: ARF register enable.
REQ-012 Mem_CS, output, 1: memory chip select, active-low.
REQ-013 Mem_WR, output, 1: memory write, 1 = write.
REQ-014 IR_Write, output, 1: IR load enable.
REQ-015 IR_LH, output, 1: IR byte select, 0 = low byte, 1 = high byte.
REQ-016 InstrValid, output, 1: the IR holds a complete 16-bit instruction.
REQ-017 State, output, 2: current FSM state, for debug.
REQ-018 FetchCount, output, 8: count of instructions acknowledged.

Function
REQ-019 The FSM SHALL have states IDLE=00, FETCH_L=01, FETCH_H=10 and HOLD=11, and all outputs except FetchCount SHALL be Moore decodes of State.
REQ-020 ARF_OutDSel SHALL be PC_OUTDSEL, ARF_FunSel SHALL be ARF_INC, and Mem_WR SHALL be 0 in every state; the block never writes memory.
REQ-021 In FETCH_L: Mem_CS=0, IR_Write=1, IR_LH=0 and ARF_RegSel=PC_REGSEL, so the low byte at PC is loaded and PC increments on the same edge.
REQ-022 In FETCH_H: Mem_CS=0, IR_Write=1, IR_LH=1 and ARF_RegSel=PC_REGSEL, so the high byte is loaded and PC increments.
REQ-023 In IDLE and HOLD: Mem_CS=1, IR_Write=0 and ARF_RegSel=3'b000.
REQ-024 InstrValid SHALL be 1 only in HOLD.
REQ-025 Transitions, first match wins:
- IDLE: Run=1 goes to FETCH_L; otherwise stay in IDLE.
- FETCH_L: Flush=1 goes to IDLE; otherwise go to FETCH_H.
- FETCH_H: Flush=1 goes to IDLE; otherwise go to HOLD.
- HOLD: Flush=1 goes to IDLE; Ack=1 with Run=1 goes to FETCH_L; Ack=1 with Run=0 goes to IDLE; otherwise stay in HOLD.
REQ-026 Fetch latency SHALL be 2 cycles: InstrValid rises on the 3rd edge after Run is sampled high in IDLE, and back-to-back instructions take 3 cycles each.
REQ-027 Run falling during FETCH_L or FETCH_H SHALL NOT abort the fetch; the instruction completes to HOLD.
REQ-028 When Flush is sampled during FETCH_L or FETCH_H, the IR write and PC increment driven in that cycle still take effect; PC therefore advances by 1 or 2 respectively.
REQ-029 Flush SHALL take priority over Ack in HOLD.
REQ-030 Ack outside HOLD SHALL be ignored.
REQ-031 FetchCount SHALL increment by 1 on each edge that leaves HOLD via Ack without Flush, wrapping from 255 to 0.

Reset
REQ-032 Reset=0 SHALL immediately, without waiting for Clock, force State=IDLE, FetchCount=0 and outputs to the IDLE decode (Mem_CS=1, IR_Write=0, ARF_RegSel=000, InstrValid=0).
REQ-033 Reset asserted mid-fetch SHALL abort the fetch with no further IR write or PC increment after assertion.
REQ-034 After Reset is released, the first fetch SHALL start only on an edge with Run=1.

Verification
REQ-035 Run=1, Ack=0 from reset: State goes 01, 10, 11 on edges 1-3; IR_LH is 0 then 1; PC advances by 2; InstrValid=1 from edge 3 and holds.
REQ-036 Run=1 and Ack pulsed in every HOLD for 4 instructions: period is 3 cycles; FetchCount=4; PC advances by 8.
REQ-037 Flush in FETCH_L: next State=IDLE; PC advanced by 1; InstrValid stays 0; FetchCount is unchanged.
REQ-038 Flush and Ack together in HOLD: State=IDLE; FetchCount is unchanged.
REQ-039 FetchCount preset to 255 by 255 acknowledged fetches, then one more Ack: FetchCount=0.
REQ-040 Reset=0 asserted mid-cycle in FETCH_H: State=IDLE and Mem_CS=1 before the next edge; release with Run=0: stays in IDLE.
